// File: rtl/core_cfg_ctrl_if.sv
// Configuration word stream: valid/ready handshake carrying target, last marker and a
// signed coefficient word.
interface core_cfg_ctrl_if #(
  parameter int COEFF_WIDTH = 20
);
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [1:0]                    cfg_target;
  logic                          cfg_last;
  logic signed [COEFF_WIDTH-1:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_target,
    output cfg_last,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_target,
    input  cfg_last,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/core_cfg_ctrl.sv
// Coefficient configuration controller: gathers a burst of words into a shadow buffer and
// commits it to the fractional decimator or one of three IIR notch sections.
module core_cfg_ctrl #(
  parameter int COEFF_WIDTH = 20,
  parameter int N_TAP       = 72,
  parameter int COEFF_DEPTH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  core_cfg_ctrl_if.slave                cfg,
  output logic                          frac_dec_coeff_wr_en,
  output logic signed [COEFF_WIDTH-1:0] frac_dec_coeff_data_in [N_TAP],
  output logic                          iir_coeff_wr_en_1MHz,
  output logic                          iir_coeff_wr_en_2MHz,
  output logic                          iir_coeff_wr_en_2_4MHz,
  output logic signed [COEFF_WIDTH-1:0] iir_coeff_in_1MHz   [COEFF_DEPTH],
  output logic signed [COEFF_WIDTH-1:0] iir_coeff_in_2MHz   [COEFF_DEPTH],
  output logic signed [COEFF_WIDTH-1:0] iir_coeff_in_2_4MHz [COEFF_DEPTH],
  output logic                          busy,
  output logic                          cfg_done,
  output logic                          cfg_error
);

  localparam int IDX_W = $clog2(N_TAP + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    COMMIT
  } state_t;

  state_t                        state;
  logic [IDX_W-1:0]              index;
  logic [1:0]                    target;
  logic signed [COEFF_WIDTH-1:0] shadow [N_TAP];

  logic             accept;
  logic [1:0]       tgt_eff;
  logic [IDX_W-1:0] expected;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] next_cnt;

  assign cfg.cfg_ready = (state != COMMIT);
  assign busy          = (state != IDLE);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

  // The first word of a burst decides the target before it has been latched.
  always_comb begin
    tgt_eff  = (state == IDLE) ? cfg.cfg_target : target;
    expected = (tgt_eff == 2'd0) ? IDX_W'(N_TAP) : IDX_W'(COEFF_DEPTH);
    wr_idx   = (state == IDLE) ? '0 : index;
    next_cnt = wr_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      index                  <= '0;
      target                 <= '0;
      frac_dec_coeff_wr_en   <= 1'b0;
      iir_coeff_wr_en_1MHz   <= 1'b0;
      iir_coeff_wr_en_2MHz   <= 1'b0;
      iir_coeff_wr_en_2_4MHz <= 1'b0;
      cfg_done               <= 1'b0;
      cfg_error              <= 1'b0;
      for (int unsigned i = 0; i < N_TAP; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      frac_dec_coeff_wr_en   <= 1'b0;
      iir_coeff_wr_en_1MHz   <= 1'b0;
      iir_coeff_wr_en_2MHz   <= 1'b0;
      iir_coeff_wr_en_2_4MHz <= 1'b0;
      cfg_done               <= 1'b0;
      cfg_error              <= 1'b0;

      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            if (state == IDLE) begin
              target <= cfg.cfg_target;
            end
            // Overflow word is dropped; if it also ends the burst there is nothing left to flush.
            if (wr_idx == expected) begin
              if (cfg.cfg_last) begin
                cfg_error <= 1'b1;
                index     <= '0;
                state     <= IDLE;
              end else begin
                state <= FLUSH;
              end
            end else begin
              shadow[wr_idx] <= cfg.cfg_data;
              index          <= next_cnt;
              if (cfg.cfg_last) begin
                if (next_cnt == expected) begin
                  frac_dec_coeff_wr_en   <= (tgt_eff == 2'd0);
                  iir_coeff_wr_en_1MHz   <= (tgt_eff == 2'd1);
                  iir_coeff_wr_en_2MHz   <= (tgt_eff == 2'd2);
                  iir_coeff_wr_en_2_4MHz <= (tgt_eff == 2'd3);
                  cfg_done               <= 1'b1;
                  state                  <= COMMIT;
                end else begin
                  cfg_error <= 1'b1;
                  index     <= '0;
                  state     <= IDLE;
                end
              end else begin
                state <= LOAD;
              end
            end
          end
        end

        FLUSH: begin
          if (accept && cfg.cfg_last) begin
            cfg_error <= 1'b1;
            index     <= '0;
            state     <= IDLE;
          end
        end

        COMMIT: begin
          index <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign frac_dec_coeff_data_in = shadow;

  for (genvar g = 0; g < COEFF_DEPTH; g++) begin : g_iir
    assign iir_coeff_in_1MHz[g]   = shadow[g];
    assign iir_coeff_in_2MHz[g]   = shadow[g];
    assign iir_coeff_in_2_4MHz[g] = shadow[g];
  end

endmodule

// File: tb/tb_core_cfg_ctrl.sv
// Bench for core_cfg_ctrl: table of directed bursts, reset corner sequences and random
// bursts checked against a burst-level reference model.
module tb_core_cfg_ctrl;

  localparam int CW    = 20;
  localparam int NT    = 72;
  localparam int DEPTH = 5;

  logic clk;
  logic rst_n;

  core_cfg_ctrl_if #(.COEFF_WIDTH(CW)) cfg_bus ();

  logic                 frac_wr;
  logic signed [CW-1:0] frac_data [NT];
  logic                 wr_1, wr_2, wr_24;
  logic signed [CW-1:0] iir_1  [DEPTH];
  logic signed [CW-1:0] iir_2  [DEPTH];
  logic signed [CW-1:0] iir_24 [DEPTH];
  logic                 busy, done, error;

  core_cfg_ctrl #(
    .COEFF_WIDTH(CW),
    .N_TAP      (NT),
    .COEFF_DEPTH(DEPTH)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cfg                   (cfg_bus),
    .frac_dec_coeff_wr_en  (frac_wr),
    .frac_dec_coeff_data_in(frac_data),
    .iir_coeff_wr_en_1MHz  (wr_1),
    .iir_coeff_wr_en_2MHz  (wr_2),
    .iir_coeff_wr_en_2_4MHz(wr_24),
    .iir_coeff_in_1MHz     (iir_1),
    .iir_coeff_in_2MHz     (iir_2),
    .iir_coeff_in_2_4MHz   (iir_24),
    .busy                  (busy),
    .cfg_done              (done),
    .cfg_error             (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int stb_seen = 0;
  int stb_exp  = 0;
  int done_mism = 0;

  logic signed [CW-1:0] mshadow [NT];

  typedef struct {
    logic [1:0] tgt;
    int         len;
    int         later_t;
    int         base;
    int         gapmax;
    bit         exp_commit;
    string      name;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [3:0] strobes();
    return {wr_24, wr_2, wr_1, frac_wr};
  endfunction

  // Each strobe must coincide with cfg_done.
  always @(negedge clk) begin
    stb_seen += $countones(strobes());
    if ((strobes() != 4'b0) != done) done_mism++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int data_mism();
    int m = 0;
    for (int i = 0; i < NT; i++) if (frac_data[i] !== mshadow[i]) m++;
    for (int i = 0; i < DEPTH; i++) begin
      if (iir_1[i]  !== mshadow[i]) m++;
      if (iir_2[i]  !== mshadow[i]) m++;
      if (iir_24[i] !== mshadow[i]) m++;
    end
    return m;
  endfunction

  task automatic send_word(input logic [1:0] t, input logic signed [CW-1:0] d,
                           input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      cfg_bus.cfg_valid  = 1'b0;
      cfg_bus.cfg_data   = CW'($urandom);
      cfg_bus.cfg_target = 2'($urandom);
      cfg_bus.cfg_last   = 1'($urandom);
    end
    @(negedge clk);
    chk("ready_before_word", cfg_bus.cfg_ready, 1);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_target = t;
    cfg_bus.cfg_data   = d;
    cfg_bus.cfg_last   = last;
    @(posedge clk);
  endtask

  task automatic run_burst(input logic [1:0] tgt, input int len, input int later_t,
                           input bit rnd, input int base, input int gapmax,
                           input bit exp_commit, input string nm);
    int                   expc;
    int                   nw;
    logic [1:0]           t;
    logic signed [CW-1:0] d [$];
    expc = (tgt == 2'd0) ? NT : DEPTH;
    d.delete();
    for (int i = 0; i < len; i++) d.push_back(rnd ? CW'($urandom) : CW'(base + i));
    for (int i = 0; i < len; i++) begin
      if (i == 0)            t = tgt;
      else if (later_t == 4) t = 2'($urandom);
      else                   t = 2'(later_t);
      send_word(t, d[i], (i == len - 1), (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
    end
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    // Reference: the first min(len, expected) words land in the shadow; only an exact count commits.
    nw = (len < expc) ? len : expc;
    for (int i = 0; i < nw; i++) mshadow[i] = d[i];
    if (exp_commit) begin
      stb_exp++;
      chk({nm, "_strobe"}, strobes(), 4'b0001 << tgt);
      chk({nm, "_done"}, done, 1);
      chk({nm, "_error"}, error, 0);
      chk({nm, "_ready_commit"}, cfg_bus.cfg_ready, 0);
      chk({nm, "_busy_commit"}, busy, 1);
      chk({nm, "_data"}, data_mism(), 0);
    end else begin
      chk({nm, "_strobe"}, strobes(), 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_error"}, error, 1);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_ready"}, cfg_bus.cfg_ready, 1);
    end
    @(negedge clk);
    chk({nm, "_after_strobe"}, strobes(), 0);
    chk({nm, "_after_pulses"}, {done, error}, 0);
    chk({nm, "_after_busy"}, busy, 0);
    chk({nm, "_after_ready"}, cfg_bus.cfg_ready, 1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NT; i++) mshadow[i] = '0;
  endtask

  initial begin
    vecs[0]  = '{2'd1,  5, 1,   1, 0, 1'b1, "t1_5w"};
    vecs[1]  = '{2'd0, 72, 0,   0, 0, 1'b1, "t0_72_b2b"};
    vecs[2]  = '{2'd2,  7, 2,   1, 0, 1'b0, "t2_over7"};
    vecs[3]  = '{2'd2,  5, 2,  10, 1, 1'b1, "t2_after_flush"};
    vecs[4]  = '{2'd3,  3, 3,   1, 0, 1'b0, "t3_short3"};
    vecs[5]  = '{2'd1,  5, 3,  20, 0, 1'b1, "t1_tgt_change"};
    vecs[6]  = '{2'd0,  1, 0,   5, 0, 1'b0, "t0_single"};
    vecs[7]  = '{2'd3,  6, 3,   7, 2, 1'b0, "t3_over_last6"};
    vecs[8]  = '{2'd0, 73, 0, 100, 0, 1'b0, "t0_73"};
    vecs[9]  = '{2'd3,  5, 3,  -5, 2, 1'b1, "t3_negative"};
    vecs[10] = '{2'd2,  1, 2,   9, 0, 1'b0, "t2_single"};

    rst_n              = 1'b0;
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_target = '0;
    cfg_bus.cfg_last   = 1'b0;
    cfg_bus.cfg_data   = '0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset_ready", cfg_bus.cfg_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_strobes", strobes(), 0);
    chk("reset_pulses", {done, error}, 0);
    chk("reset_shadow", data_mism(), 0);

    foreach (vecs[k])
      run_burst(vecs[k].tgt, vecs[k].len, vecs[k].later_t, 1'b0, vecs[k].base,
                vecs[k].gapmax, vecs[k].exp_commit, vecs[k].name);

    // Reset in the middle of a frac_dec burst.
    for (int i = 0; i < 40; i++) send_word(2'd0, CW'(1000 + i), 1'b0, 0);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    chk("mid_busy_before_rst", busy, 1);
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_strobes", strobes(), 0);
    chk("mid_rst_shadow", data_mism(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(2'd1, 5, 1, 1'b0, 11, 0, 1'b1, "post_rst_t1");

    // Reset landing in the commit cycle kills the strobe immediately.
    for (int i = 0; i < 5; i++) send_word(2'd2, CW'(50 + i), (i == 4), 0);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    chk("commit_rst_strobe_pre", strobes(), 4'b0100);
    stb_exp++;
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    chk("commit_rst_strobe", strobes(), 0);
    chk("commit_rst_done", done, 0);
    chk("commit_rst_busy", busy, 0);
    chk("commit_rst_shadow", data_mism(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random bursts: lengths clustered around the expected count, random gaps and later targets.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] tgt;
      int expc, len;
      tgt  = 2'($urandom_range(0, 3));
      expc = (tgt == 2'd0) ? NT : DEPTH;
      if ($urandom_range(0, 1) == 1) len = expc;
      else if (tgt == 2'd0) len = $urandom_range(1, 76);
      else len = $urandom_range(1, 8);
      run_burst(tgt, len, 4, 1'b1, 0, 3, (len == expc), $sformatf("rnd%0d", n));
    end

    repeat (2) @(negedge clk);
    chk("strobe_total", stb_seen, stb_exp);
    chk("strobe_done_pairing", done_mism, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_cfg_ctrl.md
CORE_CFG_CTRL -- requirements
Module: core_cfg_ctrl

Interface
REQ-001 Parameter COEFF_WIDTH, default 20: coefficient word width in bits.
REQ-002 Parameter N_TAP, default 72: fractional decimator tap count.
REQ-003 Parameter COEFF_DEPTH, default 5: coefficients per IIR notch section (3 numerator + 2 denominator).
REQ-004 clk  in  1: single clock; every register is rising-edge clocked.
REQ-005 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 cfg_valid  in  1: a configuration word is present.
REQ-007 cfg_ready  out  1: block accepts a word this cycle.
REQ-008 cfg_target  in  2: target select. 0 = frac_dec, 1 = iir_1MHz, 2 = iir_2MHz, 3 = iir_2_4MHz.
REQ-009 cfg_last  in  1: marks the final word of a burst.
REQ-010 cfg_data  in  COEFF_WIDTH, signed: coefficient word.
REQ-011 frac_dec_coeff_wr_en  out  1: single-cycle commit strobe.
REQ-012 frac_dec_coeff_data_in  out  COEFF_WIDTH x N_TAP, signed: coefficient array.
REQ-013 iir_coeff_wr_en_1MHz, iir_coeff_wr_en_2MHz, iir_coeff_wr_en_2_4MHz  out  1 each: commit strobes.
REQ-014 iir_coeff_in_1MHz, iir_coeff_in_2MHz, iir_coeff_in_2_4MHz  out  COEFF_WIDTH x COEFF_DEPTH each, signed: coefficient arrays.
REQ-015 busy  out  1: high in any state other than IDLE.
REQ-016 cfg_done  out  1: one-cycle pulse on a successful commit.
REQ-017 cfg_error  out  1: one-cycle pulse when a burst is discarded.

Function
REQ-018 The block SHALL contain a shadow buffer of N_TAP words, a word index counter of width clog2(N_TAP+1), and a latched target register.
REQ-019 A word is accepted only in a cycle where cfg_valid and cfg_ready are both high.
REQ-020 The FSM SHALL have the states IDLE, LOAD, FLUSH and COMMIT.
REQ-021 cfg_ready SHALL be high in IDLE, LOAD and FLUSH, and low in COMMIT.
REQ-022 IDLE, word accepted:
  - latch cfg_target;
  - write cfg_data to shadow[0] and set index = 1;
  - with cfg_last = 0, go to LOAD;
  - with cfg_last = 1, evaluate the burst length per REQ-025.
REQ-023 cfg_target is sampled only on the first word of a burst; its value on later words is ignored.
REQ-024 LOAD, word accepted:
  - write shadow[index] and increment index;
  - if the word would exceed the expected count (N_TAP for target 0, COEFF_DEPTH otherwise), discard it and go to FLUSH.
REQ-025 On an accepted word with cfg_last = 1 and final count == expected, go to COMMIT. On a shorter count, pulse cfg_error and go to IDLE.
REQ-026 FLUSH SHALL discard accepted words until one with cfg_last = 1, then pulse cfg_error in the following cycle and go to IDLE. No strobe is issued.
REQ-027 COMMIT lasts exactly one cycle:
  - assert the latched target's wr_en strobe and cfg_done together;
  - go to IDLE.
  - Latency: last word accepted at cycle T gives the strobe at T+1 and cfg_ready high again at T+2.
REQ-028 Exactly one wr_en strobe SHALL be high per commit, and wr_en strobes SHALL never be high outside COMMIT.
REQ-029 Data outputs:
  - frac_dec_coeff_data_in[i] = shadow[i] for all i;
  - each iir_coeff_in_*[i] = shadow[i] for i < COEFF_DEPTH;
  - outputs are valid and stable whenever a strobe is high.
REQ-030 Shadow contents SHALL persist after a commit; a later burst overwrites only the indices it writes.
REQ-031 cfg_valid low in LOAD or FLUSH SHALL hold the state indefinitely; there is no timeout.
REQ-032 busy = (state != IDLE).

Reset
REQ-033 rst_n low SHALL, asynchronously:
  - force IDLE, index = 0 and target = 0;
  - drive all wr_en strobes, cfg_done and cfg_error to 0;
  - clear the shadow buffer to 0;
  - drive cfg_ready to 1 once reset is released.
REQ-034 Reset during LOAD or FLUSH SHALL abort the burst without any strobe. Reset during COMMIT SHALL kill the strobe in that cycle.

Verification
REQ-035 Target 1 IIR burst of 5 words 1..5, last on word 5 -> iir_coeff_wr_en_1MHz and cfg_done high for exactly one cycle at T+1; iir_coeff_in_1MHz = {1,2,3,4,5}; no other strobe.
REQ-036 Target 0 burst of 72 words with back-to-back cfg_valid, data = index -> frac_dec_coeff_wr_en one cycle; frac_dec_coeff_data_in[71] = 71; cfg_ready low only in the commit cycle.
REQ-037 Target 2 burst of 7 words, last on word 7 -> words 6 and 7 discarded; cfg_error pulse one cycle after word 7; no strobe; next burst is accepted normally.
REQ-038 Target 3 burst with last on word 3 -> cfg_error pulse; no strobe; busy returns to 0 the next cycle.
REQ-039 Target 0 burst with rst_n asserted after word 40 -> busy = 0, shadow = 0, no strobe; a following 5-word target 1 burst commits correctly.
REQ-040 Target 1 burst with cfg_target changed to 3 on words 2-5 -> only iir_coeff_wr_en_1MHz strobes.
